// File: rtl/logic_probe_bank.sv
// Multi-channel logic probe: steady inputs show steady, isolated edges are stretched,
// continuous activity becomes a fixed-rate blink. One shared tick prescaler for all channels.
module logic_probe_bank #(
  parameter int CHANNELS      = 8,
  parameter int TICK_DIV      = 50000,
  parameter int STRETCH_TICKS = 8,
  parameter int BLINK_TICKS   = 16,
  parameter int SYNC          = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   probe_in,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   led_out,
  output logic [CHANNELS-1:0]   active,
  output logic                  tick
);

  localparam int MAXT = (STRETCH_TICKS > BLINK_TICKS) ? STRETCH_TICKS : BLINK_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {STEADY, HOLD, BLINK} state_t;

  logic [PW-1:0]         pcnt;
  logic [PW-1:0]         pcnt_next;
  logic [CHANNELS-1:0]   s;
  logic [CHANNELS-1:0]   prev;
  logic [CHANNELS-1:0]   chg;
  logic [CHANNELS-1:0]   pend;
  logic [2*CHANNELS-1:0] mode_q;
  logic [CW-1:0]         cnt [CHANNELS];
  state_t                st  [CHANNELS];

  always_comb begin
    pcnt_next = '0;
    if (pcnt != PW'(TICK_DIV - 1))
      pcnt_next = pcnt + 1'b1;
  end

  // tick is registered from the next count so it is 0 during reset for any TICK_DIV
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= pcnt_next;
      tick <= (pcnt_next == PW'(TICK_DIV - 1));
    end
  end

  if (SYNC != 0) begin : g_sync
    logic [CHANNELS-1:0] meta;
    logic [CHANNELS-1:0] sync;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        meta <= '0;
        sync <= '0;
      end else begin
        meta <= probe_in;
        sync <= meta;
      end
    end
    assign s = sync;
  end else begin : g_nosync
    assign s = probe_in;
  end

  assign chg = s ^ prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev    <= '0;
      led_out <= '0;
      active  <= '0;
      pend    <= '0;
      mode_q  <= mode;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        st[i]  <= STEADY;
        cnt[i] <= '0;
      end
    end else begin
      prev   <= s;
      mode_q <= mode;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        // A mode change and a non-probe mode share one path: park in STEADY, drive per new mode
        if (mode[2*i +: 2] != mode_q[2*i +: 2] || mode[2*i +: 2] != 2'b01) begin
          st[i]      <= STEADY;
          cnt[i]     <= '0;
          pend[i]    <= 1'b0;
          active[i]  <= 1'b0;
          led_out[i] <= mode[2*i+1] ? mode[2*i] : s[i];
        end else begin
          case (st[i])
            STEADY: begin
              led_out[i] <= s[i];
              if (chg[i]) begin
                st[i]     <= HOLD;
                cnt[i]    <= CW'(STRETCH_TICKS);
                pend[i]   <= 1'b0;
                active[i] <= 1'b1;
              end
            end
            default: begin
              if (tick && cnt[i] <= CW'(1)) begin
                if (pend[i] || chg[i]) begin
                  st[i]      <= BLINK;
                  led_out[i] <= ~led_out[i];
                  cnt[i]     <= CW'(BLINK_TICKS);
                  pend[i]    <= 1'b0;
                  active[i]  <= 1'b1;
                end else begin
                  st[i]      <= STEADY;
                  led_out[i] <= s[i];
                  cnt[i]     <= '0;
                  active[i]  <= 1'b0;
                end
              end else begin
                if (tick)
                  cnt[i] <= cnt[i] - 1'b1;
                if (chg[i])
                  pend[i] <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_probe_bank.sv
// Bench for logic_probe_bank: synchronised and unsynchronised instances on shared stimulus,
// checked against a tick-level behavioural model plus hand-derived vectors.
module tb_logic_probe_bank;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int BT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] probe_in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] led_a, act_a, led_b, act_b;
  logic          tick_a, tick_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_probe_bank #(.CHANNELS(CH), .TICK_DIV(TD), .STRETCH_TICKS(ST), .BLINK_TICKS(BT), .SYNC(1))
    dut_a (.clk(clk), .reset_n(reset_n), .probe_in(probe_in), .mode(mode),
           .led_out(led_a), .active(act_a), .tick(tick_a));

  logic_probe_bank #(.CHANNELS(CH), .TICK_DIV(TD), .STRETCH_TICKS(ST), .BLINK_TICKS(BT), .SYNC(0))
    dut_b (.clk(clk), .reset_n(reset_n), .probe_in(probe_in), .mode(mode),
           .led_out(led_b), .active(act_b), .tick(tick_b));

  // Reference model: per channel a phase (0 steady, 1 stretching, 2 blinking), ticks remaining
  // and a "more activity seen" flag; index 0 models the 2-clk synchronised view, 1 the raw view.
  int          m_pc;
  bit          m_tick;
  bit [CH-1:0] m_d1, m_d2;
  bit [CH-1:0] m_prev [2];
  bit [2*CH-1:0] m_modeq;
  int          m_st   [2][CH];
  int          m_rem  [2][CH];
  bit          m_pend [2][CH];
  bit [CH-1:0] m_led  [2];
  bit [CH-1:0] m_act  [2];

  task automatic model_step();
    bit [CH-1:0] view [2];
    bit s, e;
    bit [1:0] md;
    if (!reset_n) begin
      m_pc = 0; m_tick = 0; m_d1 = '0; m_d2 = '0; m_modeq = mode;
      for (int k = 0; k < 2; k++) begin
        m_prev[k] = '0; m_led[k] = '0; m_act[k] = '0;
        for (int i = 0; i < CH; i++) begin
          m_st[k][i] = 0; m_rem[k][i] = 0; m_pend[k][i] = 0;
        end
      end
      return;
    end
    view[0] = m_d2;
    view[1] = probe_in;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < CH; i++) begin
        s  = view[k][i];
        e  = (s != m_prev[k][i]);
        md = mode[2*i +: 2];
        if (md != m_modeq[2*i +: 2] || md != 2'b01) begin
          m_st[k][i] = 0; m_rem[k][i] = 0; m_pend[k][i] = 0;
          m_led[k][i] = (md == 2'b11) ? 1'b1 : (md == 2'b10) ? 1'b0 : s;
        end else if (m_st[k][i] == 0) begin
          m_led[k][i] = s;
          if (e) begin
            m_st[k][i] = 1; m_rem[k][i] = ST; m_pend[k][i] = 0;
          end
        end else if (m_tick) begin
          m_rem[k][i] = m_rem[k][i] - 1;
          if (m_rem[k][i] == 0) begin
            if (m_pend[k][i] || e) begin
              m_led[k][i] = ~m_led[k][i];
              m_rem[k][i] = BT; m_pend[k][i] = 0; m_st[k][i] = 2;
            end else begin
              m_led[k][i] = s; m_st[k][i] = 0;
            end
          end else if (e) m_pend[k][i] = 1;
        end else if (e) m_pend[k][i] = 1;
        m_act[k][i] = (m_st[k][i] != 0);
      end
    end
    m_prev[0] = m_d2;
    m_prev[1] = probe_in;
    m_d2 = m_d1;
    m_d1 = probe_in;
    m_modeq = mode;
    m_pc = (m_pc + 1) % TD;
    m_tick = (m_pc == TD - 1);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("led_a", led_a, m_led[0]);
    chk("act_a", act_a, m_act[0]);
    chk("tick_a", tick_a, m_tick);
    chk("led_b", led_b, m_led[1]);
    chk("act_b", act_b, m_act[1]);
    chk("tick_b", tick_b, m_tick);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    probe_in = '0;
    mode = '0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          rst_n;
    bit [CH-1:0] probe;
    bit [2*CH-1:0] md;
    bit [CH-1:0] led_a;
    bit [CH-1:0] act_a;
    bit          tck;
    bit [CH-1:0] led_b;
    bit [CH-1:0] act_b;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes, found;
    logic prev_led;

    // reset, then ch0 in probe mode sees a single rising edge
    tbl[0]  = '{0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 4'h0};
    tbl[1]  = '{0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 4'h0};
    tbl[2]  = '{0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 4'h0};
    tbl[3]  = '{1, 4'h0, 8'h01, 4'h0, 4'h0, 0, 4'h0, 4'h0};
    tbl[4]  = '{1, 4'h1, 8'h01, 4'h0, 4'h0, 0, 4'h1, 4'h1};
    tbl[5]  = '{1, 4'h1, 8'h01, 4'h0, 4'h0, 1, 4'h1, 4'h1};
    tbl[6]  = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h1};
    tbl[7]  = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h1};
    tbl[8]  = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h1};
    tbl[9]  = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 1, 4'h1, 4'h1};
    tbl[10] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h1};
    tbl[11] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h1};
    tbl[12] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h1};
    tbl[13] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 1, 4'h1, 4'h1};
    tbl[14] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h0};
    tbl[15] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h0};
    tbl[16] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 0, 4'h1, 4'h0};
    tbl[17] = '{1, 4'h1, 8'h01, 4'h1, 4'h1, 1, 4'h1, 4'h0};
    tbl[18] = '{1, 4'h1, 8'h01, 4'h1, 4'h0, 0, 4'h1, 4'h0};
    tbl[19] = '{1, 4'h1, 8'h01, 4'h1, 4'h0, 0, 4'h1, 4'h0};
    tbl[20] = '{1, 4'h1, 8'h01, 4'h1, 4'h0, 0, 4'h1, 4'h0};
    tbl[21] = '{1, 4'h1, 8'h01, 4'h1, 4'h0, 1, 4'h1, 4'h0};

    for (int r = 0; r < 22; r++) begin
      reset_n  = tbl[r].rst_n;
      probe_in = tbl[r].probe;
      mode     = tbl[r].md;
      step();
      chk("tbl_led_a", led_a, tbl[r].led_a);
      chk("tbl_act_a", act_a, tbl[r].act_a);
      chk("tbl_tick", tick_a, tbl[r].tck);
      chk("tbl_led_b", led_b, tbl[r].led_b);
      chk("tbl_act_b", act_b, tbl[r].act_b);
    end

    // ch3: edge reaches the synchronised sample exactly on the clk HOLD expires
    do_reset();
    mode = 8'h40;
    for (int r = 3; r < 27; r++) begin
      probe_in = (r >= 4 && r <= 15) ? 4'h8 : 4'h0;
      step();
      if (r == 17) begin
        chk("exp_edge_pre_led", led_a[3], 1'b1);
        chk("exp_edge_pre_act", act_a[3], 1'b1);
      end
      if (r == 18) begin
        chk("exp_edge_led", led_a[3], 1'b0);
        chk("exp_edge_act", act_a[3], 1'b1);
      end
      if (r == 22) chk("exp_edge_blink", act_a[3], 1'b1);
      if (r == 26) chk("exp_edge_done", act_a[3], 1'b0);
    end

    // ch1 square wave, 3 high / 3 low
    do_reset();
    mode = 8'h04;
    for (int c = 0; c < 60; c++) begin
      probe_in = ((c / 3) % 2 == 1) ? 4'h2 : 4'h0;
      step();
    end
    changes = 0;
    prev_led = led_a[1];
    for (int c = 60; c < 76; c++) begin
      probe_in = ((c / 3) % 2 == 1) ? 4'h2 : 4'h0;
      step();
      if (led_a[1] !== prev_led) changes++;
      prev_led = led_a[1];
    end
    chk("sq_toggles", changes, 2);
    chk("sq_active", act_a[1], 1'b1);
    probe_in = 4'h0;
    repeat (30) step();
    chk("sq_stop_led", led_a[1], 1'b0);
    chk("sq_stop_act", act_a[1], 1'b0);

    // ch2 forced on with activity, then ch1 switched to follow mid-blink
    mode = 8'h34;
    for (int c = 0; c < 40; c++) begin
      probe_in = ((c / 3) % 2 == 1) ? 4'h6 : 4'h0;
      step();
    end
    chk("force_on_led", led_a[2], 1'b1);
    chk("force_on_act", act_a[2], 1'b0);
    chk("pre_switch_act", act_a[1], 1'b1);
    mode = 8'h30;
    probe_in = 4'h0;
    step();
    chk("switch_act_a", act_a[1], 1'b0);
    chk("switch_act_b", act_b[1], 1'b0);
    repeat (4) step();
    probe_in = 4'h2;
    step();
    step();
    chk("follow_lat2", led_a[1], 1'b0);
    step();
    chk("follow_lat3", led_a[1], 1'b1);

    // reset while ch1 blinks with its LED lit
    mode = 8'h04;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      probe_in = ((c / 3) % 2 == 1) ? 4'h2 : 4'h0;
      step();
      if (m_st[0][1] == 2 && m_led[0][1] == 1'b1) found = 1;
    end
    chk("blink_lit_found", found, 1);
    reset_n = 1'b0;
    step();
    chk("rst_led", led_a, 4'h0);
    chk("rst_act", act_a, 4'h0);
    chk("rst_tick", tick_a, 1'b0);
    probe_in = 4'h0;
    step();
    reset_n = 1'b1;
    repeat (40) step();
    chk("rst_quiet_led", led_a[1], 1'b0);
    chk("rst_quiet_act", act_a[1], 1'b0);

    // randomized traffic with per-channel activity levels, mode changes and resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499, 0) == 0) reset_n = 1'b0;
      else if (!reset_n && $urandom_range(2, 0) == 0) reset_n = 1'b1;
      if ($urandom_range(99, 0) == 0) mode[2*$urandom_range(CH-1, 0) +: 2] = 2'($urandom_range(3, 0));
      if ($urandom_range(39, 0) == 0) probe_in[0] = ~probe_in[0];
      if ($urandom_range(2, 0) == 0)  probe_in[1] = ~probe_in[1];
      if ($urandom_range(9, 0) == 0)  probe_in[2] = ~probe_in[2];
      if ($urandom_range(1, 0) == 0)  probe_in[3] = ~probe_in[3];
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
